// File: rtl/eth_stream_pkg.sv
// Shared stream types and helpers for the Ethernet TX/RX datapath.
// Holds the beat bundle, arbiter states and the round-robin pick function.
package eth_stream_pkg;

    localparam int ETH_MAX_BEATS = 190;

    typedef struct packed {
        logic [63:0] tdata;
        logic [7:0]  tkeep;
        logic        tlast;
        logic        tuser;
    } axis64_t;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        PASS,
        DRAIN
    } arb_state_t;

    // First requester after 'last', wrapping modulo n; keeps 'last' if none.
    function automatic logic [2:0] rr_pick(
        input logic [7:0]  req,
        input logic [2:0]  last,
        input int unsigned n
    );
        logic [2:0] pick;
        logic [2:0] idx;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= 8; k++) begin
            idx = 3'((32'(last) + k) % n);
            if (k <= n && !found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// Multi-lane AXI-Stream bundle; lane i occupies slice i of each vector.
// master drives valid/data, slave drives ready.
interface eth_tx_arbiter_if #(
    parameter int LANES  = 1,
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8
);

    logic [LANES-1:0]        tvalid;
    logic [LANES-1:0]        tready;
    logic [LANES*DATA_W-1:0] tdata;
    logic [LANES*KEEP_W-1:0] tkeep;
    logic [LANES-1:0]        tlast;
    logic [LANES-1:0]        tuser;

    modport master (
        output tvalid,
        output tdata,
        output tkeep,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tuser,
        output tready
    );

endinterface

// File: rtl/eth_rr_pick.sv
// Combinational round-robin priority encoder over up to 8 requesters.
// Shared by the TX arbiter and the RX-side demux.
module eth_rr_pick
    import eth_stream_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [IW-1:0]      pick,
    output logic               any
);

    logic [7:0] req8;
    logic [2:0] last3;
    logic [2:0] pick3;

    always_comb begin
        req8  = 8'(req);
        last3 = 3'(last);
        pick3 = rr_pick(req8, last3, NUM_SRC);
    end

    assign pick = IW'(pick3);
    assign any  = |req;

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-atomic round-robin arbiter sharing one AXI-S TX path to the MAC.
// Grants hold until tlast; a beat watchdog truncates runaway frames.
module eth_tx_arbiter
    import eth_stream_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
    parameter int NUM_SRC      = 4,
    parameter int MAX_BEATS    = ETH_MAX_BEATS,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 eth_clk,
    input  logic                 sys_rst,
    eth_tx_arbiter_if.slave      s,
    eth_tx_arbiter_if.master     m,
    input  logic [NUM_SRC-1:0]   src_en,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0] trunc_cnt,
    output logic                 busy
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int BW = $clog2(MAX_BEATS + 1);

    arb_state_t state, state_nxt;

    logic [1:0]              rst_pipe;
    logic                    arst;
    logic [IW-1:0]           grant;
    logic [IW-1:0]           last_grant;
    logic [IW-1:0]           pick;
    logic                    pick_any;
    logic [BW-1:0]           beat_cnt;
    logic [NUM_SRC-1:0]      req;
    logic                    sel_valid;
    logic                    sel_last;
    logic                    sel_user;
    logic [C_DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0]   sel_keep;
    logic                    at_max;
    logic                    beat_acc;
    logic                    drain_done;
    logic                    frame_inc;
    logic                    trunc_inc;

    // Assert immediately, release two edges later in the eth_clk domain.
    always_ff @(posedge eth_clk or posedge sys_rst) begin
        if (sys_rst) rst_pipe <= 2'b11;
        else         rst_pipe <= {rst_pipe[0], 1'b0};
    end

    assign arst = rst_pipe[1];

    assign req       = s.tvalid & src_en;
    assign sel_valid = s.tvalid[grant];
    assign sel_last  = s.tlast[grant];
    assign sel_user  = s.tuser[grant];
    assign sel_data  = s.tdata[int'(grant)*C_DATA_WIDTH +: C_DATA_WIDTH];
    assign sel_keep  = s.tkeep[int'(grant)*KEEP_WIDTH +: KEEP_WIDTH];
    assign at_max    = (beat_cnt == BW'(MAX_BEATS - 1));

    assign beat_acc   = (state == PASS) && sel_valid && m.tready[0];
    assign drain_done = (state == DRAIN) && sel_valid && sel_last;
    assign frame_inc  = beat_acc && (sel_last || at_max);
    assign trunc_inc  = beat_acc && !sel_last && at_max;
    assign busy       = (state != IDLE);

    eth_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IW      (IW)
    ) u_pick (
        .req  (req),
        .last (last_grant),
        .pick (pick),
        .any  (pick_any)
    );

    always_ff @(posedge eth_clk or posedge arst) begin
        if (arst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (|req) state_nxt = ARB;
            ARB:   state_nxt = pick_any ? PASS : IDLE;
            PASS: begin
                if (beat_acc) begin
                    if (sel_last)    state_nxt = IDLE;
                    else if (at_max) state_nxt = DRAIN;
                end
            end
            DRAIN: if (drain_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m.tvalid = '0;
        m.tdata  = '0;
        m.tkeep  = '0;
        m.tlast  = '0;
        m.tuser  = '0;
        s.tready = '0;
        unique case (state)
            PASS: begin
                m.tvalid[0]     = sel_valid;
                m.tdata         = sel_data;
                m.tkeep         = sel_keep;
                m.tlast[0]      = sel_last | at_max;
                m.tuser[0]      = sel_user | (at_max & ~sel_last);
                s.tready[grant] = m.tready[0];
            end
            DRAIN:   s.tready[grant] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge eth_clk or posedge arst) begin
        if (arst) begin
            grant      <= '0;
            last_grant <= IW'(NUM_SRC - 1);
            beat_cnt   <= '0;
            frame_cnt  <= '0;
            trunc_cnt  <= '0;
        end else begin
            if (state == ARB) begin
                beat_cnt <= '0;
                if (pick_any) grant <= pick;
            end
            if (beat_acc) beat_cnt <= beat_cnt + 1'b1;
            if ((beat_acc && sel_last) || drain_done) last_grant <= grant;
            if (frame_inc && frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
            if (trunc_inc && trunc_cnt != '1) trunc_cnt <= trunc_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: per-source beat queues feed the DUT,
// accepted MAC beats are collected and compared with hand-built frames.
module tb_eth_tx_arbiter;
    import eth_stream_pkg::*;

    localparam int NS = 4;

    logic             eth_clk = 1'b0;
    logic             sys_rst;
    logic [NS-1:0]    src_en;
    logic [31:0]      frame_cnt;
    logic [31:0]      trunc_cnt;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    axis64_t src_q[NS][$];
    axis64_t out_q[$];
    int      out_cyc[$];

    logic    mready;
    logic    smp_mvalid;
    logic    smp_mready;
    axis64_t smp_beat;
    logic [NS-1:0] smp_sready;

    eth_tx_arbiter_if #(.LANES(NS), .DATA_W(64)) src_if ();
    eth_tx_arbiter_if #(.LANES(1),  .DATA_W(64)) mac_if ();

    eth_tx_arbiter #(
        .C_DATA_WIDTH (64),
        .NUM_SRC      (NS),
        .MAX_BEATS    (190),
        .CNT_WIDTH    (32)
    ) dut (
        .eth_clk   (eth_clk),
        .sys_rst   (sys_rst),
        .s         (src_if.slave),
        .m         (mac_if.master),
        .src_en    (src_en),
        .frame_cnt (frame_cnt),
        .trunc_cnt (trunc_cnt),
        .busy      (busy)
    );

    always #10 eth_clk = ~eth_clk;

    function automatic axis64_t mk_beat(int src, int id, int b, int n,
                                        logic [7:0] lkeep);
        axis64_t r;
        r.tdata = {8'(src), 8'(id), 16'(b), 32'h600D_F00D};
        r.tkeep = (b == n - 1) ? lkeep : 8'hFF;
        r.tlast = (b == n - 1);
        r.tuser = 1'b0;
        return r;
    endfunction

    task automatic push_frame(int src, int id, int n, logic [7:0] lkeep);
        for (int b = 0; b < n; b++) src_q[src].push_back(mk_beat(src, id, b, n, lkeep));
    endtask

    task automatic drive_src();
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() > 0) begin
                src_if.tvalid[i]          = 1'b1;
                src_if.tdata[i*64 +: 64]  = src_q[i][0].tdata;
                src_if.tkeep[i*8 +: 8]    = src_q[i][0].tkeep;
                src_if.tlast[i]           = src_q[i][0].tlast;
                src_if.tuser[i]           = src_q[i][0].tuser;
            end else begin
                src_if.tvalid[i]          = 1'b0;
                src_if.tdata[i*64 +: 64]  = '0;
                src_if.tkeep[i*8 +: 8]    = '0;
                src_if.tlast[i]           = 1'b0;
                src_if.tuser[i]           = 1'b0;
            end
        end
        mac_if.tready[0] = mready;
    endtask

    // Entered on a falling edge; samples just before the next rising edge.
    task automatic cycle();
        drive_src();
        #8;
        smp_mvalid = mac_if.tvalid[0];
        smp_mready = mac_if.tready[0];
        smp_beat   = '{tdata: mac_if.tdata, tkeep: mac_if.tkeep,
                       tlast: mac_if.tlast[0], tuser: mac_if.tuser[0]};
        smp_sready = src_if.tready;
        if (smp_mvalid && smp_mready) begin
            out_q.push_back(smp_beat);
            out_cyc.push_back(cyc);
        end
        for (int i = 0; i < NS; i++)
            if (src_if.tvalid[i] && src_if.tready[i]) void'(src_q[i].pop_front());
        cyc++;
        @(negedge eth_clk);
    endtask

    task automatic clear_all();
        for (int i = 0; i < NS; i++) src_q[i].delete();
        out_q.delete();
        out_cyc.delete();
    endtask

    task automatic do_reset();
        clear_all();
        mready  = 1'b1;
        src_en  = '1;
        sys_rst = 1'b1;
        drive_src();
        repeat (2) @(negedge eth_clk);
        sys_rst = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic test_reset();
        clear_all();
        mready  = 1'b1;
        src_en  = '1;
        sys_rst = 1'b1;
        push_frame(0, 0, 2, 8'hFF);
        drive_src();
        repeat (2) @(negedge eth_clk);
        checks++;
        if (mac_if.tvalid !== 1'b0)
            $display("FAIL reset_mvalid: got %b want 0", mac_if.tvalid);
        checks++;
        if (src_if.tready !== 4'b0000)
            $display("FAIL reset_sready: got %b want 0000", src_if.tready);
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        checks++;
        if (frame_cnt !== 32'd0) $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt);
        checks++;
        if (trunc_cnt !== 32'd0) $display("FAIL reset_trunc_cnt: got %0d want 0", trunc_cnt);
        if (mac_if.tvalid !== 1'b0 || src_if.tready !== 4'b0000 || busy !== 1'b0 ||
            frame_cnt !== 32'd0 || trunc_cnt !== 32'd0) errors++;
        clear_all();
        sys_rst = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic test_single();
        int c0, n;
        axis64_t exp;
        do_reset();
        push_frame(0, 1, 8, 8'hF0);
        c0 = cyc;
        n  = 0;
        while (out_q.size() < 8 && n < 60) begin cycle(); n++; end
        checks++;
        if (out_q.size() != 8) begin
            errors++;
            $display("FAIL single_count: got %0d beats want 8", out_q.size());
        end
        for (int b = 0; b < out_q.size() && b < 8; b++) begin
            exp = mk_beat(0, 1, b, 8, 8'hF0);
            checks++;
            if (out_q[b] !== exp) begin
                errors++;
                $display("FAIL single_beat%0d: got %h want %h", b, out_q[b], exp);
            end
        end
        if (out_cyc.size() == 8) begin
            checks++;
            if (out_cyc[0] != c0 + 2) begin
                errors++;
                $display("FAIL single_leadin: got %0d want %0d", out_cyc[0] - c0, 2);
            end
            checks++;
            if (out_cyc[7] != c0 + 9) begin
                errors++;
                $display("FAIL single_contig: got %0d want %0d", out_cyc[7] - c0, 9);
            end
        end
        cycle();
        checks++;
        if (frame_cnt !== 32'd1) begin
            errors++;
            $display("FAIL single_frame_cnt: got %0d want 1", frame_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_round_robin();
        int n;
        axis64_t exp;
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < 3; s++) push_frame(s, r, 3, 8'h0F);
        n = 0;
        while (out_q.size() < 18 && n < 200) begin cycle(); n++; end
        checks++;
        if (out_q.size() != 18) begin
            errors++;
            $display("FAIL rr_count: got %0d beats want 18", out_q.size());
        end
        for (int k = 0; k < 18 && k < out_q.size(); k++) begin
            exp = mk_beat((k / 3) % 3, k / 9, k % 3, 3, 8'h0F);
            checks++;
            if (out_q[k] !== exp) begin
                errors++;
                $display("FAIL rr_beat%0d: got %h want %h", k, out_q[k], exp);
            end
        end
        for (int f = 1; f < 6 && 3 * f < out_cyc.size(); f++) begin
            checks++;
            if (out_cyc[3*f] - out_cyc[3*f-1] != 3) begin
                errors++;
                $display("FAIL rr_gap%0d: got %0d idle want 2", f,
                         out_cyc[3*f] - out_cyc[3*f-1] - 1);
            end
        end
        cycle();
        checks++;
        if (frame_cnt !== 32'd6) begin
            errors++;
            $display("FAIL rr_frame_cnt: got %0d want 6", frame_cnt);
        end
    endtask

    task automatic test_truncate();
        int n;
        axis64_t exp;
        do_reset();
        push_frame(1, 7, 195, 8'hFF);
        n = 0;
        while ((src_q[1].size() > 0 || busy) && n < 400) begin cycle(); n++; end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL trunc_timeout: got %0d cycles want <400", n);
        end
        checks++;
        if (out_q.size() != 190) begin
            errors++;
            $display("FAIL trunc_count: got %0d beats want 190", out_q.size());
        end
        if (out_q.size() >= 190) begin
            exp = mk_beat(1, 7, 0, 195, 8'hFF);
            checks++;
            if (out_q[0] !== exp) begin
                errors++;
                $display("FAIL trunc_first: got %h want %h", out_q[0], exp);
            end
            checks++;
            if (out_q[188].tlast !== 1'b0) begin
                errors++;
                $display("FAIL trunc_beat189_last: got %b want 0", out_q[188].tlast);
            end
            exp = mk_beat(1, 7, 189, 195, 8'hFF);
            exp.tlast = 1'b1;
            exp.tuser = 1'b1;
            checks++;
            if (out_q[189] !== exp) begin
                errors++;
                $display("FAIL trunc_last: got %h want %h", out_q[189], exp);
            end
        end
        checks++;
        if (trunc_cnt !== 32'd1 || frame_cnt !== 32'd1) begin
            errors++;
            $display("FAIL trunc_cnts: got frame=%0d trunc=%0d want 1 1", frame_cnt, trunc_cnt);
        end
    endtask

    task automatic test_src_en();
        int n;
        logic saw_rdy1;
        axis64_t exp;
        int exp_src[3];
        do_reset();
        src_en = 4'b1101;
        for (int s = 0; s < NS; s++) push_frame(s, 3, 2, 8'hFF);
        saw_rdy1 = 1'b0;
        n = 0;
        while (out_q.size() < 6 && n < 100) begin
            cycle();
            saw_rdy1 |= smp_sready[1];
            n++;
        end
        repeat (6) begin cycle(); saw_rdy1 |= smp_sready[1]; end
        checks++;
        if (saw_rdy1 !== 1'b0 || out_q.size() != 6) begin
            errors++;
            $display("FAIL mask_src1: got rdy1=%b beats=%0d want 0 6", saw_rdy1, out_q.size());
        end
        exp_src = '{0, 2, 3};
        for (int k = 0; k < 6 && k < out_q.size(); k++) begin
            exp = mk_beat(exp_src[k/2], 3, k % 2, 2, 8'hFF);
            checks++;
            if (out_q[k] !== exp) begin
                errors++;
                $display("FAIL mask_beat%0d: got %h want %h", k, out_q[k], exp);
            end
        end
        src_en = 4'b1111;
        out_q.delete();
        out_cyc.delete();
        push_frame(0, 4, 2, 8'hFF);
        push_frame(2, 4, 2, 8'hFF);
        n = 0;
        while (out_q.size() < 6 && n < 100) begin cycle(); n++; end
        checks++;
        if (out_q.size() != 6) begin
            errors++;
            $display("FAIL unmask_count: got %0d beats want 6", out_q.size());
        end
        if (out_q.size() == 6) begin
            checks++;
            if (out_q[0].tdata[63:48] !== 16'h0004 || out_q[2].tdata[63:48] !== 16'h0103 ||
                out_q[4].tdata[63:48] !== 16'h0204) begin
                errors++;
                $display("FAIL unmask_order: got %h %h %h want 0004 0103 0204",
                         out_q[0].tdata[63:48], out_q[2].tdata[63:48], out_q[4].tdata[63:48]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic pv, pr;
        axis64_t pb, exp;
        do_reset();
        push_frame(2, 5, 4, 8'h3F);
        mready = 1'b1;
        smp_mvalid = 1'b0;
        smp_mready = 1'b1;
        n = 0;
        while (out_q.size() < 4 && n < 40) begin
            pv = smp_mvalid;
            pr = smp_mready;
            pb = smp_beat;
            cycle();
            mready = ~mready;
            if (pv && !pr) begin
                checks++;
                if (!(smp_mvalid === 1'b1 && smp_beat === pb)) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b %h want v=1 %h", smp_mvalid, smp_beat, pb);
                end
            end
            n++;
        end
        mready = 1'b1;
        repeat (4) cycle();
        checks++;
        if (out_q.size() != 4) begin
            errors++;
            $display("FAIL stall_count: got %0d beats want 4", out_q.size());
        end
        for (int b = 0; b < 4 && b < out_q.size(); b++) begin
            exp = mk_beat(2, 5, b, 4, 8'h3F);
            checks++;
            if (out_q[b] !== exp) begin
                errors++;
                $display("FAIL stall_beat%0d: got %h want %h", b, out_q[b], exp);
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        axis64_t exp;
        do_reset();
        push_frame(2, 6, 2, 8'hFF);
        n = 0;
        while (out_q.size() < 2 && n < 40) begin cycle(); n++; end
        repeat (2) cycle();
        checks++;
        if (frame_cnt !== 32'd1) begin
            errors++;
            $display("FAIL arst_pre_cnt: got %0d want 1", frame_cnt);
        end
        push_frame(3, 8, 6, 8'hFF);
        n = 0;
        while (out_q.size() < 4 && n < 40) begin cycle(); n++; end
        drive_src();
        #3;
        sys_rst = 1'b1;
        #1;
        checks++;
        if (mac_if.tvalid !== 1'b0 || src_if.tready !== 4'b0000) begin
            errors++;
            $display("FAIL arst_drop: got mvalid=%b sready=%b want 0 0000",
                     mac_if.tvalid, src_if.tready);
        end
        sys_rst = 1'b0;
        out_q.delete();
        out_cyc.delete();
        push_frame(0, 9, 2, 8'hFF);
        @(negedge eth_clk);
        checks++;
        if (frame_cnt !== 32'd0 || trunc_cnt !== 32'd0) begin
            errors++;
            $display("FAIL arst_cnts: got %0d %0d want 0 0", frame_cnt, trunc_cnt);
        end
        n = 0;
        while (out_q.size() < 2 && n < 40) begin cycle(); n++; end
        exp = mk_beat(0, 9, 0, 2, 8'hFF);
        checks++;
        if (out_q.size() < 1 || out_q[0] !== exp) begin
            errors++;
            $display("FAIL arst_first_grant: got %h want %h",
                     (out_q.size() > 0) ? out_q[0] : '0, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        sys_rst       = 1'b1;
        src_en        = '1;
        mready        = 1'b1;
        src_if.tvalid = '0;
        src_if.tdata  = '0;
        src_if.tkeep  = '0;
        src_if.tlast  = '0;
        src_if.tuser  = '0;
        mac_if.tready = 1'b1;
        @(negedge eth_clk);
        test_reset();
        test_single();
        test_round_robin();
        test_truncate();
        test_src_en();
        test_backpressure();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
Frame-atomic round-robin arbiter that shares one 64-bit AXI-Stream Ethernet TX path between NUM_SRC frame sources. Example sources are the TLP-to-UDP encapsulator, the ARP/ICMP responder and a debug frame generator.
A grant is held from the first beat of a frame until its tlast, so frames never interleave. A per-frame beat watchdog truncates runaway frames. Per-source enable masking and saturating statistics counters are provided.
Sits between the packet builders and the MAC TX interface, in the eth_clk domain.

Parameters:
C_DATA_WIDTH, 64, stream data width in bits
KEEP_WIDTH, C_DATA_WIDTH/8, tkeep width
NUM_SRC, 4, number of sources (2..8)
MAX_BEATS, 190, longest legal frame in beats (1518 B jumbo-free frame = 190 beats)
CNT_WIDTH, 32, statistics counter width

Ports:
eth_clk  in  1  clock
sys_rst  in  1  reset, asynchronous, active-high
s_tvalid  in  NUM_SRC  per-source valid
s_tready  out  NUM_SRC  per-source ready
s_tdata  in  NUM_SRC*C_DATA_WIDTH  source i data at slice [i*C_DATA_WIDTH +: C_DATA_WIDTH]
s_tkeep  in  NUM_SRC*KEEP_WIDTH  per-source keep, packed the same way
s_tlast  in  NUM_SRC  per-source last
s_tuser  in  NUM_SRC  per-source error flag
m_tvalid  out  1  to MAC
m_tready  in  1  from MAC
m_tdata  out  C_DATA_WIDTH  to MAC
m_tkeep  out  KEEP_WIDTH  to MAC
m_tlast  out  1  to MAC
m_tuser  out  1  to MAC; 1 = abort/bad frame
src_en  in  NUM_SRC  quasi-static enable mask
frame_cnt  out  CNT_WIDTH  frames completed on m_*, saturating
trunc_cnt  out  CNT_WIDTH  frames truncated by watchdog, saturating
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release on eth_clk):
  - state=IDLE, grant=0, last_grant=NUM_SRC-1, beat_cnt=0.
  - Counters=0; m_tvalid=0; s_tready=0; busy=0.
- States: IDLE, ARB, PASS, DRAIN.
- IDLE:
  - If (s_tvalid & src_en) != 0, go to ARB next cycle.
  - All s_tready=0; m_tvalid=0.
- ARB:
  - grant <= first i with s_tvalid[i] & src_en[i], searching from last_grant+1 modulo NUM_SRC.
  - beat_cnt <= 0; go to PASS.
  - If no request remains, return to IDLE.
  - Arbitration costs exactly 2 bubble cycles between frames (IDLE, ARB).
- PASS: combinational pass-through, zero latency.
  - m_* = s_*[grant]; s_tready[grant] = m_tready; other s_tready = 0.
  - Beat accepted = m_tvalid & m_tready; beat_cnt increments per accepted beat.
  - Accepted beat with tlast: last_grant <= grant; frame_cnt++; go to IDLE.
  - Accepted beat without tlast while beat_cnt == MAX_BEATS-1:
    - Output that beat with m_tlast=1 and m_tuser=1 forced.
    - frame_cnt++, trunc_cnt++; go to DRAIN.
- DRAIN:
  - m_tvalid=0; s_tready[grant]=1.
  - Discard source beats until one with s_tlast is taken, then last_grant <= grant and go to IDLE.
- src_en:
  - Sampled only at ARB.
  - Deasserting src_en for the granted source mid-frame does not abort the frame.
- Source tuser passes through unchanged in PASS.
- Counters saturate at all-ones. When both counters increment in the same cycle, both increment.
- Reset mid-frame: outputs drop immediately (asynchronous). No partial-frame recovery is attempted; the MAC sees m_tvalid fall without tlast.
- Sources must hold tvalid/data stable until ready (AXI-S rule). The arbiter never deasserts m_tvalid mid-beat except on reset.

Decomposition:
- Package eth_stream_pkg:
  - Typedef axis64_t {tdata[63:0], tkeep[7:0], tlast, tuser}.
  - Enum arb_state_t.
  - Constant ETH_MAX_BEATS=190.
  - Function rr_pick(req, last) returning the next index.
- One sub-module: eth_rr_pick, a combinational round-robin priority encoder. It is reusable by the RX-side demux.

Test Plan:
- Single source 0, 8-beat frame (last beat tkeep=8'hF0), m_tready=1 -> identical 8 beats on m_*, tkeep 8'hF0 on beat 8, frame_cnt=1, 2-cycle lead-in from IDLE.
- Sources 0,1,2 continuously valid, 3-beat frames each -> output order 0,1,2,0,1,2, no interleaving. Each frame separated by exactly 2 idle cycles. frame_cnt=6 after 6 frames.
- Source 1 frame of 195 beats, MAX_BEATS=190 -> 190 beats out, beat 190 with m_tlast=1 and m_tuser=1. Remaining 5 beats accepted with m_tvalid=0. trunc_cnt=1, frame_cnt=1, then IDLE.
- src_en=4'b1101 with all sources valid -> source 1 never granted, s_tready[1] stays 0. Setting src_en[1]=1 makes it next in rotation order.
- m_tready toggled 1010 during a 4-beat frame -> beats held stable while ready=0, exactly 4 beats out, no duplicate or drop.
- sys_rst pulsed for 1 ns mid-frame asynchronously to eth_clk -> m_tvalid=0 and s_tready=0 immediately. After release, arbitration starts from source 0 and counters read 0.
